seven_segment_decoder: RTL and testbench
========================================

// Module: seven_segment_decoder
// PURPOSE
//  Recovers digit values from a multiplexed, scanned seven-segment display bus. It is the
//  inverse of the seven_segment encoder path: segment patterns in, 4-bit values out.
//  Samples one-hot digit strobes plus segment lines and requires STABLE_CYCLES identical
//  samples before capturing a digit. Stores one value per digit and pulses frame_valid once
//  every digit has been captured. Used as the display-readback checker and scoreboard front end.
// PARAMETERS
//  NUM_DIGITS     4   digits on the scanned bus (>=1)
//  STABLE_CYCLES  4   consecutive identical registered samples needed to capture (>=2, <=255)
// PORTS
//  clk           in   1             single clock, rising edge
//  rst           in   1             synchronous, active-high reset
//  digit_sel     in   NUM_DIGITS    one-hot digit strobe, active-high; bit i = digit i
//  segments      in   7             bit0=a .. bit6=g, active-high
//  values        out  4*NUM_DIGITS  digit i in [4i+3:4i]
//  blank         out  NUM_DIGITS    digit i last captured as 7'b0000000
//  invalid       out  NUM_DIGITS    digit i last captured as an undefined pattern
//  sample_valid  out  1             1-cycle pulse per capture
//  sample_idx    out  8             index of the digit captured with sample_valid
//  frame_valid   out  1             1-cycle pulse: all digits captured since last frame
// BEHAVIOUR
//  Reset:
//   - All outputs 0; FSM -> IDLE; stability counter 0; seen-mask 0; input regs 0.
//   - Reset mid-frame discards the partial frame. No frame_valid is produced for it.
//  Input stage:
//   - digit_sel and segments are registered once (r_sel, r_seg).
//   - A sample is the pair {r_sel, r_seg}.
//  Stability counter:
//   - If r_sel is not one-hot (zero or multiple bits set): cnt <= 0 and no capture.
//   - Else if sample == previous sample: cnt increments, saturating at STABLE_CYCLES.
//   - Else: cnt <= 1.
//   - Capture fires only on the cycle cnt goes STABLE_CYCLES-1 -> STABLE_CYCLES.
//     This gives exactly one capture per stable window. A held pattern never recaptures.
//  Capture latency:
//   - sample_valid is high exactly STABLE_CYCLES+1 cycles after the first edge at which
//     the new input pair is present.
//   - values, blank, invalid and sample_idx update in that same cycle.
//  Decode table (segments -> value):
//   - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9.
//   - 00 -> value 0, blank=1, invalid=0.
//   - Any other pattern -> value 4'hF, invalid=1, blank=0.
//   - Valid digit patterns clear both blank and invalid for that digit.
//   - Only digit i's fields change on a capture of digit i.
//  Frame FSM:
//   - IDLE: on first capture, set seen[idx] and go to COLLECT.
//     If NUM_DIGITS==1, go straight to DONE.
//   - COLLECT: each capture sets seen[idx]. A recapture of an already-seen digit
//     overwrites its value but does not count twice.
//     When seen becomes all-ones -> DONE.
//   - DONE: one cycle. frame_valid=1, seen<=0, then go to COLLECT.
//     A capture arriving in the DONE cycle sets seen[idx] for the new frame.
//     Captures are at least STABLE_CYCLES apart, so this is the only overlap possible.
//   - frame_valid is asserted the cycle after the last digit's sample_valid.
//     values are stable while frame_valid is high.
//  Width rules:
//   - cnt is 8 bits; sample_idx is zero-extended to 8 bits.
//   - Values of digit_sel when not one-hot are never captured.
// TESTING
//  1. rst held 3 cycles, then released -> all outputs 0; no pulses for 20 idle cycles.
//  2. NUM_DIGITS=4, STABLE=4. Drive sel=0001, seg=5B for 10 cycles
//     -> one sample_valid at +5 cycles, idx=0, values[3:0]=2, then no further pulses.
//  3. Scan digits 0..3 with 5B, 66, 7F, 00, 6 cycles each
//     -> values=16'h0842, blank=4'b1000, frame_valid 1 cycle after the 4th capture.
//  4. Hold seg=7F but glitch to 7E for 1 cycle at cnt=3
//     -> no capture; capture 5 cycles after glitch ends. Then seg=12 -> value F, invalid[i]=1.
//  5. sel=0000 and sel=0011, each held 10 cycles
//     -> no sample_valid; outputs unchanged.
//  6. Capture digits 0 and 1, assert rst 1 cycle, then capture 2 and 3
//     -> no frame_valid; frame_valid only after 0 and 1 are captured again.

Source files
------------

// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder
// Reads back a scanned, multiplexed seven-segment bus and recovers one 4-bit value per digit.
// A digit is captured once its strobe/segment pair has been held for STABLE_CYCLES
// consecutive registered samples. A capture goes through one decode register before it
// reaches the outputs. frame_valid pulses after every digit has been captured at least once.
//
// Handshake: sample_valid is a one-cycle pulse with no back-pressure. sample_idx, values,
// blank and invalid are updated in the same cycle as the pulse. frame_valid is a one-cycle
// pulse in the cycle after the sample_valid that completes a frame. values hold steady
// while frame_valid is high.
module seven_segment_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   digit_sel,
    input  logic [6:0]              segments,
    output logic [4*NUM_DIGITS-1:0] values,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic [NUM_DIGITS-1:0]   invalid,
    output logic                    sample_valid,
    output logic [7:0]              sample_idx,
    output logic                    frame_valid,
    output logic [1:0]              state_dbg
);

    localparam logic [7:0]            STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] ALL_SEEN   = '1;
    localparam logic [NUM_DIGITS-1:0] ONE        = NUM_DIGITS'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Input stage and the previous sample used for the stability comparison
    logic [NUM_DIGITS-1:0] r_sel;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] p_sel;
    logic [6:0]            p_seg;
    logic [7:0]            cnt;

    // Decode stage: the captured pair waiting to be decoded
    logic                  cap_v;
    logic [NUM_DIGITS-1:0] cap_sel;
    logic [6:0]            cap_seg;

    // Strobe of the digit reported by the current sample_valid
    logic [NUM_DIGITS-1:0] out_sel;

    // Frame tracking
    state_t                state;
    state_t                state_nxt;
    logic [NUM_DIGITS-1:0] seen;
    logic [NUM_DIGITS-1:0] seen_nxt;
    logic [NUM_DIGITS-1:0] sv_bit;

    logic                  sel_onehot;
    logic                  same_sample;
    logic                  capture;

    logic [3:0]            dec_val;
    logic                  dec_blank;
    logic                  dec_invalid;
    logic [7:0]            cap_idx;

    // A sample only counts when exactly one digit strobe is active
    always_comb begin
        sel_onehot  = (r_sel != '0) && ((r_sel & (r_sel - ONE)) == '0);
        same_sample = (r_sel == p_sel) && (r_seg == p_seg);
        capture     = sel_onehot && same_sample && (cnt == STABLE_MAX - 8'd1);
    end

    // Register the raw bus and keep the previous sample for comparison
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel <= '0;
            r_seg <= '0;
            p_sel <= '0;
            p_seg <= '0;
        end else begin
            r_sel <= digit_sel;
            r_seg <= segments;
            p_sel <= r_sel;
            p_seg <= r_seg;
        end
    end

    // Stability counter: counts identical one-hot samples and saturates at STABLE_CYCLES
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!sel_onehot) begin
            cnt <= '0;
        end else if (same_sample) begin
            if (cnt < STABLE_MAX) begin
                cnt <= cnt + 8'd1;
            end
        end else begin
            cnt <= 8'd1;
        end
    end

    // Hold the captured pair for one cycle so it can be decoded
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_v   <= 1'b0;
            cap_sel <= '0;
            cap_seg <= '0;
        end else begin
            cap_v <= capture;
            if (capture) begin
                cap_sel <= r_sel;
                cap_seg <= r_seg;
            end
        end
    end

    // Segment pattern to digit value; blank and undefined patterns are flagged separately
    always_comb begin
        dec_val     = 4'hF;
        dec_blank   = 1'b0;
        dec_invalid = 1'b0;
        case (cap_seg)
            7'h3F:   dec_val = 4'd0;
            7'h06:   dec_val = 4'd1;
            7'h5B:   dec_val = 4'd2;
            7'h4F:   dec_val = 4'd3;
            7'h66:   dec_val = 4'd4;
            7'h6D:   dec_val = 4'd5;
            7'h7D:   dec_val = 4'd6;
            7'h07:   dec_val = 4'd7;
            7'h7F:   dec_val = 4'd8;
            7'h6F:   dec_val = 4'd9;
            7'h00: begin
                dec_val   = 4'd0;
                dec_blank = 1'b1;
            end
            default: begin
                dec_val     = 4'hF;
                dec_invalid = 1'b1;
            end
        endcase
    end

    // Convert the captured one-hot strobe to a zero-extended digit index
    always_comb begin
        cap_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap_sel[i]) begin
                cap_idx = 8'(i);
            end
        end
    end

    // Output registers: only the captured digit's fields change
    always_ff @(posedge clk) begin
        if (rst) begin
            values       <= '0;
            blank        <= '0;
            invalid      <= '0;
            sample_valid <= 1'b0;
            sample_idx   <= '0;
            out_sel      <= '0;
        end else begin
            sample_valid <= cap_v;
            if (cap_v) begin
                sample_idx <= cap_idx;
                out_sel    <= cap_sel;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (cap_sel[i]) begin
                        values[4*i +: 4] <= dec_val;
                        blank[i]         <= dec_blank;
                        invalid[i]       <= dec_invalid;
                    end
                end
            end
        end
    end

    // Frame state and seen-mask registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            seen  <= '0;
        end else begin
            state <= state_nxt;
            seen  <= seen_nxt;
        end
    end

    // Frame next-state: accumulate captured digits, pulse DONE once all are seen
    always_comb begin
        state_nxt   = state;
        seen_nxt    = seen;
        frame_valid = 1'b0;
        sv_bit      = sample_valid ? out_sel : '0;
        case (state)
            IDLE: begin
                if (sample_valid) begin
                    seen_nxt  = sv_bit;
                    state_nxt = (sv_bit == ALL_SEEN) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (sample_valid) begin
                    seen_nxt = seen | sv_bit;
                    if ((seen | sv_bit) == ALL_SEEN) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                frame_valid = 1'b1;
                seen_nxt    = sv_bit;
                state_nxt   = (sample_valid && (sv_bit == ALL_SEEN)) ? DONE : COLLECT;
            end
            default: begin
                state_nxt = IDLE;
                seen_nxt  = '0;
            end
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// tb_seven_segment_decoder
// Scoreboard bench: the driver feeds a reference model at the level of held input patterns,
// pushes the expected capture (with its due cycle) into exp_q, and a monitor pops and compares.
module tb_seven_segment_decoder;

  localparam int ND = 4;
  localparam int ST = 4;

  logic            clk;
  logic            rst;
  logic [ND-1:0]   digit_sel;
  logic [6:0]      segments;
  logic [4*ND-1:0] values;
  logic [ND-1:0]   blank;
  logic [ND-1:0]   invalid;
  logic            sample_valid;
  logic [7:0]      sample_idx;
  logic            frame_valid;
  logic [1:0]      state_dbg;

  seven_segment_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(ST)) dut (
    .clk          (clk),
    .rst          (rst),
    .digit_sel    (digit_sel),
    .segments     (segments),
    .values       (values),
    .blank        (blank),
    .invalid      (invalid),
    .sample_valid (sample_valid),
    .sample_idx   (sample_idx),
    .frame_valid  (frame_valid),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [7:0]      idx;
    logic [4*ND-1:0] vals;
    logic [ND-1:0]   blk;
    logic [ND-1:0]   inv;
    logic            frame;
    logic [31:0]     due;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  logic [6:0] pats [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // reference model state (input-pattern level)
  logic [ND-1:0]   m_last_sel = '0;
  logic [6:0]      m_last_seg = '0;
  int              m_run = 0;
  logic [4*ND-1:0] m_vals = '0;
  logic [ND-1:0]   m_blk = '0;
  logic [ND-1:0]   m_inv = '0;
  logic [ND-1:0]   m_seen = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic decode_ref(input logic [6:0] seg, output logic [3:0] v, output logic b, output logic x);
    v = 4'hF; b = 1'b0; x = 1'b1;
    if (seg == 7'h00) begin
      v = 4'h0; b = 1'b1; x = 1'b0;
    end else begin
      for (int k = 0; k < 10; k++) begin
        if (pats[k] == seg) begin
          v = 4'(k); x = 1'b0;
        end
      end
    end
  endtask

  // one input cycle seen by the model; a run reaching ST identical one-hot samples is a capture
  task automatic model_step(input logic [ND-1:0] sel, input logic [6:0] seg);
    int prev;
    int idx;
    logic [3:0] v;
    logic b, x, fr;
    exp_t e;
    prev = m_run;
    if ($countones(sel) != 1) m_run = 0;
    else if (sel == m_last_sel && seg == m_last_seg) m_run = (m_run < ST) ? m_run + 1 : m_run;
    else m_run = 1;
    m_last_sel = sel;
    m_last_seg = seg;
    if (m_run == ST && prev == ST - 1) begin
      idx = 0;
      for (int i = 0; i < ND; i++) if (sel[i]) idx = i;
      decode_ref(seg, v, b, x);
      m_vals[4*idx +: 4] = v;
      m_blk[idx] = b;
      m_inv[idx] = x;
      m_seen = m_seen | sel;
      fr = (m_seen == '1);
      if (fr) m_seen = '0;
      e.idx = 8'(idx);
      e.vals = m_vals;
      e.blk = m_blk;
      e.inv = m_inv;
      e.frame = fr;
      e.due = 32'(cyc + 2);
      exp_q.push_back(e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [ND-1:0] sel, input logic [6:0] seg, input int len);
    repeat (len) begin
      digit_sel = sel;
      segments = seg;
      @(posedge clk);
      #1;
      model_step(sel, seg);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    digit_sel = '0;
    segments = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    m_last_sel = '0; m_last_seg = '0; m_run = 0;
    m_vals = '0; m_blk = '0; m_inv = '0; m_seen = '0;
  endtask

  task automatic check_held(input string name);
    @(negedge clk);
    chk({name, "_values"}, 64'(values), 64'(m_vals));
    chk({name, "_blank"}, 64'(blank), 64'(m_blk));
    chk({name, "_invalid"}, 64'(invalid), 64'(m_inv));
  endtask

  // ---------------- monitor ----------------
  logic pend_frame = 1'b0;
  logic [4*ND-1:0] last_vals = '0;
  exp_t e_mon;

  always @(negedge clk) begin
    if (rst) begin
      pend_frame = 1'b0;
      last_vals = '0;
    end else begin
      chk("frame_valid", 64'(frame_valid), 64'(pend_frame));
      if (frame_valid) chk("frame_values_stable", 64'(values), 64'(last_vals));
      pend_frame = 1'b0;
      while (exp_q.size() > 0 && exp_q[0].due < 32'(cyc)) begin
        e_mon = exp_q.pop_front();
        chk("missing_sample_valid", 64'(0), 64'(e_mon.due));
      end
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_sample_valid", 64'(sample_idx), 64'hFFFF);
        end else begin
          e_mon = exp_q.pop_front();
          chk("sample_cycle", 64'(cyc), 64'(e_mon.due));
          chk("sample_idx", 64'(sample_idx), 64'(e_mon.idx));
          chk("values", 64'(values), 64'(e_mon.vals));
          chk("blank", 64'(blank), 64'(e_mon.blk));
          chk("invalid", 64'(invalid), 64'(e_mon.inv));
          pend_frame = e_mon.frame;
          last_vals = e_mon.vals;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [ND-1:0] rs;
  logic [6:0]    rg;
  int            pick;

  initial begin
    rst = 1'b1;
    digit_sel = '0;
    segments = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_values", 64'(values), 64'(0));
    chk("rst_blank", 64'(blank), 64'(0));
    chk("rst_invalid", 64'(invalid), 64'(0));
    chk("rst_sample_valid", 64'(sample_valid), 64'(0));
    chk("rst_sample_idx", 64'(sample_idx), 64'(0));
    chk("rst_frame_valid", 64'(frame_valid), 64'(0));
    #1;
    drive('0, 7'h00, 20);

    // single held digit: one capture only
    drive(4'b0001, 7'h5B, 10);
    drive('0, 7'h00, 8);

    // full scan
    drive(4'b0001, 7'h5B, 6);
    drive(4'b0010, 7'h66, 6);
    drive(4'b0100, 7'h7F, 6);
    drive(4'b1000, 7'h00, 6);
    drive('0, 7'h00, 8);
    check_held("scan");
    chk("scan_values_const", 64'(values), 64'h0842);
    chk("scan_blank_const", 64'(blank), 64'b1000);
    #1;

    // glitch before capture, then an undefined pattern
    drive(4'b0010, 7'h7F, 3);
    drive(4'b0010, 7'h7E, 1);
    drive(4'b0010, 7'h7F, 8);
    drive(4'b0010, 7'h12, 6);
    drive('0, 7'h00, 8);
    check_held("glitch");
    #1;

    // non one-hot strobes never capture
    drive(4'b0000, 7'h06, 10);
    drive(4'b0011, 7'h06, 10);
    drive('0, 7'h00, 8);
    check_held("nonhot");
    #1;

    // reset mid-frame discards partial frame
    drive(4'b0001, 7'h06, 6);
    drive(4'b0010, 7'h4F, 6);
    drive('0, 7'h00, 8);
    do_reset(1);
    drive(4'b0100, 7'h6D, 6);
    drive(4'b1000, 7'h7D, 6);
    drive(4'b0001, 7'h07, 6);
    drive(4'b0010, 7'h6F, 6);
    drive('0, 7'h00, 8);
    check_held("midreset");
    #1;

    // randomized scanning
    for (int n = 0; n < 300; n++) begin
      pick = $urandom_range(0, 9);
      if (pick == 0) rs = ND'($urandom_range(0, (1 << ND) - 1));
      else rs = ND'(1) << $urandom_range(0, ND - 1);
      pick = $urandom_range(0, 9);
      if (pick < 7) rg = pats[$urandom_range(0, 9)];
      else if (pick == 7) rg = 7'h00;
      else rg = 7'($urandom_range(0, 127));
      drive(rs, rg, $urandom_range(1, 8));
    end
    drive('0, 7'h00, 10);
    check_held("random_end");

    chk("exp_q_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // overall time bound
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
